// File: rtl/shot_seq_pkg.sv
// Shared types and widths for the shot sequencer: FSM state encoding,
// counter widths and the timer load-value helper.
package shot_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRST = 3'd1,
    ST_RUN  = 3'd2,
    ST_HOLD = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam int unsigned HOLD_W = 16;
  localparam int unsigned TOUT_W = 24;

  // A timer loaded with N-1 reaches zero on its N-th cycle in the state.
  function automatic logic [HOLD_W-1:0] hold_load(input logic [HOLD_W-1:0] cycles);
    return cycles - {{(HOLD_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/shot_timer.sv
// Loadable down-counter with a zero flag. Load has priority over
// decrement; the count saturates at zero.
module shot_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Count register: load, else decrement while non-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != '0)) begin
      count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign zero = (count_r == '0);

endmodule

// File: rtl/shot_sequencer.sv
// Shot sequencer: runs nshot experiment shots on a set of processor cores.
// Each shot is a reset pulse (PRST), a run phase that ends when every
// participating core has signalled end-of-program (RUN), and an optional
// idle gap (HOLD). A RUN timeout and a level abort both abandon the
// experiment. All outputs are registered.
module shot_sequencer
  import shot_seq_pkg::*;
#(
  parameter int unsigned NPROC  = 4,
  parameter int unsigned RSTCYC = 2,
  parameter int unsigned SHOTW  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stb_start,
  input  logic [SHOTW-1:0]  nshot,
  input  logic [HOLD_W-1:0] holdoff,
  input  logic [TOUT_W-1:0] timeout,
  input  logic [NPROC-1:0]  procmask,
  input  logic              abort,
  input  logic [NPROC-1:0]  procend,
  output logic [NPROC-1:0]  proc_reset,
  output logic              busy,
  output logic [SHOTW-1:0]  shotcnt,
  output logic              stb_shotdone,
  output logic              lastshotdone,
  output logic              timeout_err
);

  localparam logic [HOLD_W-1:0] PRST_LOAD = hold_load(HOLD_W'(RSTCYC));

  logic [1:0]        rst_sync_r;
  logic              rst_n_s;
  state_e            state_r, next_s;
  logic [SHOTW-1:0]  nshot_r, shotcnt_r, shot_next_s;
  logic [HOLD_W-1:0] holdoff_r, ph_val_s;
  logic [TOUT_W-1:0] timeout_r, run_val_s;
  logic [NPROC-1:0]  mask_r, status_r, proc_reset_r;
  logic              busy_r, stb_shotdone_r, lastshotdone_r, timeout_err_r;
  logic              ph_load_s, ph_dec_s, ph_zero_s;
  logic              run_load_s, run_dec_s, run_zero_s;
  logic              complete_s, start_ok_s, zero_start_s, shot_done_s, tout_s;

  // Reset synchronizer: assert asynchronously, release on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s     = rst_sync_r[1];
  assign complete_s  = &(status_r | ~mask_r);
  assign shot_next_s = shotcnt_r + {{(SHOTW-1){1'b0}}, 1'b1};
  assign ph_dec_s    = (state_r == ST_PRST) || (state_r == ST_HOLD);
  assign run_dec_s   = (state_r == ST_RUN);

  shot_timer #(.W(HOLD_W)) u_phase_timer (
    .clk      (clk),
    .rst_n    (rst_n_s),
    .load     (ph_load_s),
    .load_val (ph_val_s),
    .dec      (ph_dec_s),
    .zero     (ph_zero_s)
  );

  shot_timer #(.W(TOUT_W)) u_run_timer (
    .clk      (clk),
    .rst_n    (rst_n_s),
    .load     (run_load_s),
    .load_val (run_val_s),
    .dec      (run_dec_s),
    .zero     (run_zero_s)
  );

  // Next-state logic and timer loads; abort beats completion and timeout.
  always_comb begin
    next_s       = state_r;
    ph_load_s    = 1'b0;
    ph_val_s     = PRST_LOAD;
    run_load_s   = 1'b0;
    run_val_s    = timeout_r - {{(TOUT_W-1){1'b0}}, 1'b1};
    start_ok_s   = 1'b0;
    zero_start_s = 1'b0;
    shot_done_s  = 1'b0;
    tout_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (stb_start) begin
          if (nshot != '0) begin
            start_ok_s = 1'b1;
            ph_load_s  = 1'b1;
            next_s     = ST_PRST;
          end else begin
            zero_start_s = 1'b1;
          end
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_PRST: begin
        if (abort) begin
          next_s = ST_IDLE;
        end else if (ph_zero_s) begin
          run_load_s = 1'b1;
          next_s     = ST_RUN;
        end else begin
          next_s = ST_PRST;
        end
      end
      ST_RUN: begin
        if (abort) begin
          next_s = ST_IDLE;
        end else if (complete_s) begin
          shot_done_s = 1'b1;
          if (shot_next_s == nshot_r) begin
            next_s = ST_DONE;
          end else if (holdoff_r == '0) begin
            ph_load_s = 1'b1;
            next_s    = ST_PRST;
          end else begin
            ph_load_s = 1'b1;
            ph_val_s  = hold_load(holdoff_r);
            next_s    = ST_HOLD;
          end
        end else if ((timeout_r != '0) && run_zero_s) begin
          tout_s = 1'b1;
          next_s = ST_IDLE;
        end else begin
          next_s = ST_RUN;
        end
      end
      ST_HOLD: begin
        if (abort) begin
          next_s = ST_IDLE;
        end else if (ph_zero_s) begin
          ph_load_s = 1'b1;
          next_s    = ST_PRST;
        end else begin
          next_s = ST_HOLD;
        end
      end
      ST_DONE: begin
        next_s = ST_IDLE;
      end
      default: begin
        next_s = ST_IDLE;
      end
    endcase
  end

  // State register and experiment parameters captured on an accepted start.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r   <= ST_IDLE;
      nshot_r   <= '0;
      holdoff_r <= '0;
      timeout_r <= '0;
      mask_r    <= '0;
    end else begin
      state_r <= next_s;
      if (start_ok_s) begin
        nshot_r   <= nshot;
        holdoff_r <= holdoff;
        timeout_r <= timeout;
        mask_r    <= procmask;
      end
    end
  end

  // Per-core sticky end-of-program status; only collected in RUN.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      status_r <= '0;
    end else if (state_r == ST_RUN) begin
      status_r <= status_r | (procend & mask_r);
    end else begin
      status_r <= '0;
    end
  end

  // Shot counter and sticky timeout flag, both cleared by an accepted start.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      shotcnt_r     <= '0;
      timeout_err_r <= 1'b0;
    end else if (start_ok_s) begin
      shotcnt_r     <= '0;
      timeout_err_r <= 1'b0;
    end else begin
      if (shot_done_s) begin
        shotcnt_r <= shot_next_s;
      end
      if (tout_s) begin
        timeout_err_r <= 1'b1;
      end
    end
  end

  // Registered outputs derived from the state being entered.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      proc_reset_r   <= '1;
      busy_r         <= 1'b0;
      stb_shotdone_r <= 1'b0;
      lastshotdone_r <= 1'b0;
    end else begin
      proc_reset_r   <= (next_s == ST_RUN) ? ~mask_r : '1;
      busy_r         <= (next_s != ST_IDLE);
      stb_shotdone_r <= shot_done_s;
      lastshotdone_r <= (next_s == ST_DONE) || zero_start_s;
    end
  end

  assign proc_reset   = proc_reset_r;
  assign busy         = busy_r;
  assign shotcnt      = shotcnt_r;
  assign stb_shotdone = stb_shotdone_r;
  assign lastshotdone = lastshotdone_r;
  assign timeout_err  = timeout_err_r;

endmodule

// File: doc/shot_sequencer.md
SHOT_SEQUENCER -- requirements
Module: shot_sequencer

Interface
REQ-001 Parameter NPROC, default 4, number of processor cores sequenced.
REQ-002 Parameter RSTCYC, default 2, cycles proc_reset is held at the start of each shot (range 1..15).
REQ-003 Parameter SHOTW, default 32, width of the shot count.
REQ-004 clk  input  1  sole clock; all logic rising-edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 stb_start  input  1  one-cycle strobe that starts an nshot experiment.
REQ-007 nshot  input  SHOTW  number of shots, sampled on stb_start.
REQ-008 holdoff  input  16  idle cycles between shots, sampled on stb_start.
REQ-009 timeout  input  24  maximum RUN cycles per shot (0 = disabled), sampled on stb_start.
REQ-010 procmask  input  NPROC  cores participating, sampled on stb_start.
REQ-011 abort  input  1  level request to abandon the experiment.
REQ-012 procend  input  NPROC  per-core end-of-program strobe.
REQ-013 proc_reset  output  NPROC  per-core reset to the processor cores.
REQ-014 busy  output  1  high from the accepted start until return to IDLE.
REQ-015 shotcnt  output  SHOTW  count of completed shots.
REQ-016 stb_shotdone  output  1  one-cycle pulse per completed shot.
REQ-017 lastshotdone  output  1  one-cycle pulse when the final shot completes.
REQ-018 timeout_err  output  1  sticky flag: a shot exceeded timeout.

Function
REQ-019 FSM states SHALL be IDLE, PRST, RUN, HOLD and DONE, all transitions registered.
REQ-020 In IDLE, proc_reset SHALL be all-ones and busy SHALL be 0.
REQ-021 A stb_start in IDLE with nshot != 0 SHALL latch nshot, holdoff, timeout and procmask, clear shotcnt and timeout_err, and enter PRST on the next cycle.
REQ-022 A stb_start in IDLE with nshot == 0 SHALL leave the FSM in IDLE and pulse lastshotdone on the next cycle.
REQ-023 A stb_start outside IDLE SHALL be ignored.
REQ-024 PRST SHALL last exactly RSTCYC cycles with proc_reset all-ones and per-core done status cleared, then enter RUN.
REQ-025 In RUN, proc_reset SHALL be ~procmask_latched, and procend[i] SHALL set sticky status[i] only when procmask_latched[i] is set.
REQ-026 Shot completion SHALL be detected when (status | ~procmask_latched) is all-ones; a zero mask therefore completes on the first RUN cycle.
REQ-027 On completion, the block SHALL increment shotcnt and pulse stb_shotdone on the same registered edge; it SHALL enter DONE if the new shotcnt equals nshot, otherwise HOLD.
REQ-028 HOLD SHALL last holdoff cycles (0 means zero cycles, going straight to PRST) with proc_reset all-ones, then enter PRST.
REQ-029 DONE SHALL last one cycle, pulse lastshotdone and go to IDLE.
REQ-030 A RUN cycle counter SHALL reset on RUN entry.
REQ-031 If timeout != 0 and the RUN cycle counter reaches timeout before completion, the block SHALL set timeout_err, leave shotcnt unchanged, issue no stb_shotdone, and go to IDLE.
REQ-032 abort high in any non-IDLE state SHALL force IDLE on the next cycle, with proc_reset all-ones, no lastshotdone, and shotcnt retained.
REQ-033 If abort and completion coincide, abort SHALL win.
REQ-034 procend during PRST or HOLD SHALL be ignored.
REQ-035 Latency: stb_start at cycle N gives busy=1 and proc_reset all-ones from N+1, RUN from N+1+RSTCYC.

Reset
REQ-036 While reset_n is low, the block SHALL force state=IDLE, proc_reset all-ones, shotcnt=0, busy=0, and stb_shotdone=0, lastshotdone=0, timeout_err=0.
REQ-037 Reset asserted mid-experiment SHALL abandon it immediately with no pulses issued.
REQ-038 Reset deassertion SHALL be synchronized to clk inside the block.

Structure
REQ-039 The state enum and the widths of the holdoff and timeout counters SHALL live in package shot_seq_pkg.
REQ-040 One sub-module, shot_timer, SHALL implement a loadable down-counter with a zero flag, instanced for both PRST/HOLD timing and the RUN timeout.

Verification
REQ-041 nshot=3, holdoff=5, procmask=4'b1111, all procend 10 cycles into RUN -> three stb_shotdone pulses, shotcnt=3, one lastshotdone, 5-cycle HOLD between shots.
REQ-042 procmask=4'b0101, procend only on cores 0,2 -> shot completes, proc_reset[1] and proc_reset[3] stay 1 throughout RUN.
REQ-043 timeout=20, core 3 never ends -> timeout_err=1 at RUN cycle 20, IDLE, shotcnt unchanged, no lastshotdone.
REQ-044 nshot=0 -> busy stays 0, lastshotdone pulses once at N+1.
REQ-045 abort in HOLD of shot 2 of 4 -> IDLE next cycle, shotcnt=2, no lastshotdone.
REQ-046 reset_n low during RUN and a second stb_start while busy -> all outputs at reset values immediately, and the second start is ignored.
